// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO on a valid/ready port.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err pulse and parity-bad bytes dropped.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_ADDR_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic [FIFO_ADDR_W:0] fifo_cnt
);

    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0]          BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]          HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]          CNT_ONE   = CW'(1);
    localparam logic [FIFO_ADDR_W:0]   OCC_FULL  = (FIFO_ADDR_W + 1)'(DEPTH);
    localparam logic [FIFO_ADDR_W:0]   OCC_ONE   = (FIFO_ADDR_W + 1)'(1);
    localparam logic [FIFO_ADDR_W-1:0] PTR_ONE   = FIFO_ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // rx is asynchronous; only the second synchronizer flop is ever looked at
    logic rx_m, rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    state_t          state, state_nx;
    logic [CW-1:0]   clk_cnt, cnt_nx;
    logic [2:0]      bit_idx, idx_nx;
    logic [7:0]      shift, shift_nx;
    logic            push;
    logic            ferr_nx;
`ifdef UART_RX_PARITY_EN
    logic            par_bad, pbad_nx;
    logic            perr_nx;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = clk_cnt;
        idx_nx   = bit_idx;
        shift_nx = shift;
        push     = 1'b0;
        ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_nx  = par_bad;
        perr_nx  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nx = S_START;
                    cnt_nx   = '0;
`ifdef UART_RX_PARITY_EN
                    pbad_nx  = 1'b0;
`endif
                end
            end
            S_START: begin
                // mid-start-bit recheck rejects glitches shorter than half a bit
                if (clk_cnt == HALF_LAST) begin
                    cnt_nx = '0;
                    if (!rx_s) begin
                        state_nx = S_DATA;
                        idx_nx   = '0;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    cnt_nx = clk_cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    cnt_nx            = '0;
                    shift_nx[bit_idx] = rx_s;
                    idx_nx            = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = S_PARITY;
`else
                        state_nx = S_STOP;
`endif
                    end
                end else begin
                    cnt_nx = clk_cnt + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (clk_cnt == BIT_LAST) begin
                    cnt_nx   = '0;
                    pbad_nx  = ^{shift, rx_s};
                    perr_nx  = ^{shift, rx_s};
                    state_nx = S_STOP;
                end else begin
                    cnt_nx = clk_cnt + CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    cnt_nx = '0;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        push = !par_bad;
`else
                        push = 1'b1;
`endif
                        state_nx = S_IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = S_BREAK;
                    end
                end else begin
                    cnt_nx = clk_cnt + CNT_ONE;
                end
            end
            // a low stop bit usually means a break; don't hunt for starts until the line idles
            S_BREAK: begin
                if (rx_s) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            clk_cnt   <= cnt_nx;
            bit_idx   <= idx_nx;
            shift     <= shift_nx;
            frame_err <= ferr_nx;
`ifdef UART_RX_PARITY_EN
            par_bad    <= pbad_nx;
            parity_err <= perr_nx;
`endif
        end
    end

    logic [DEPTH-1:0][7:0]   mem;
    logic [FIFO_ADDR_W-1:0]  wptr, rptr;
    logic                    pop, full, wr_en;

    assign rx_valid = (fifo_cnt != '0);
    assign pop      = rx_valid && rx_ready;
    assign full     = (fifo_cnt == OCC_FULL);
    // when full, a same-cycle pop frees the head slot that wptr already points at
    assign wr_en    = push && (!full || pop);
    assign rx_data  = rx_valid ? mem[rptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
            overrun  <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (wr_en) wptr <= wptr + PTR_ONE;
            if (pop)   rptr <= rptr + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   fifo_cnt <= fifo_cnt + OCC_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - OCC_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule
